sll_sequential: RTL
===================

Name: sll_sequential

Overview:
Multicycle logical left shifter for the CPU execute path. It is the left-direction counterpart of the combinational arithmetic-right barrel stages. It reuses one 2:1 mux row per cycle: the latched operand passes through stages 16, 8, 4, 2, 1 in order, one stage per clock. It has a start/ready handshake so the multdiv-style stall logic can treat it like the other multicycle units.

Parameters:
SHAMT_BITS, 5, number of shift-amount bits and number of shift stages.
WIDTH, 32, data width; must equal 2**SHAMT_BITS.

Ports:
clock  input  1  rising-edge system clock.
reset  input  1  asynchronous, active-high reset.
ctrl_start  input  1  request a shift; sampled only when busy=0.
data_operandA  input  WIDTH  operand to shift; sampled with ctrl_start.
ctrl_shiftamt  input  SHAMT_BITS  shift amount 0..WIDTH-1; sampled with ctrl_start.
data_result  output  WIDTH  shifted result; holds its value until the next accepted start.
data_resultRDY  output  1  one-cycle pulse when data_result becomes valid.
busy  output  1  high while a shift is in progress.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is asynchronous and active-high.
- Reset values: data_result=0, data_resultRDY=0, busy=0. Internal state = IDLE, stage counter = 0, shamt register = 0.
- States: IDLE and SHIFT.
- IDLE -> SHIFT:
  - Taken at the edge where ctrl_start=1.
  - At that edge: operand is loaded into the working register, ctrl_shiftamt into the shamt register, counter is set to 0, busy=1.
- SHIFT, each edge with counter k (0..SHAMT_BITS-1):
  - Stage bit index = SHAMT_BITS-1-k.
  - If shamt[index]=1: work = work << 2**index, vacated LSBs filled with 0.
  - Otherwise: work unchanged.
  - Counter increments.
- Exit from SHIFT, at the edge where k=SHAMT_BITS-1:
  - The final stage is applied directly into data_result.
  - data_resultRDY=1 for exactly the following cycle.
  - busy=0; state returns to IDLE.
- Latency is fixed and independent of shift amount:
  - Start sampled at edge N; result valid and RDY high after edge N+SHAMT_BITS (5 cycles for defaults).
  - shamt=0 still takes 5 cycles and returns the operand unchanged.
- Bits shifted past the MSB are discarded. There is no overflow flag.
- data_resultRDY deasserts on the next edge unless a new shift completes on that edge.
- Changing inputs while busy: ctrl_start=1 is ignored. data_operandA and ctrl_shiftamt changes have no effect.
- Back-to-back operation:
  - ctrl_start=1 in the RDY cycle is accepted, since busy=0.
  - RDY drops, busy rises, and data_result keeps the previous value until the new completion.
- Reset mid-operation: the in-flight shift is aborted immediately (async). All outputs return to reset values and no RDY pulse is produced.
- The working register is not visible externally. data_result updates only on completion or reset.

Test Plan:
- Reset release, then idle 3 cycles -> data_result=0x00000000, data_resultRDY=0, busy=0 throughout.
- Start with A=0x00000001, shamt=31 at edge N -> busy high edges N..N+4; after N+5, result=0x80000000 and RDY high for one cycle.
- A=0xFFFFFFFF, shamt=4 -> result=0xFFFFFFF0 after 5 cycles. Then A=0x12345678, shamt=0 -> result=0x12345678, still 5-cycle latency.
- A=0x0000000F, shamt=30 -> result=0xC0000000 (upper bits discarded). During busy, assert start with A=0xFFFFFFFF, shamt=1 -> ignored, result still 0xC0000000.
- Back-to-back: A=0x00000003, shamt=8 completes (0x00000300); start in RDY cycle with A=0x00000300, shamt=8 -> 0x00030000 five cycles later; result holds 0x00000300 meanwhile.
- Assert reset asynchronously at cycle 2 of a shift (A=0x1, shamt=16) -> outputs 0 immediately, no RDY pulse. A new start after release yields 0x00010000 with normal latency.

Source files
------------

// File: rtl/sll_sequential.sv
// Multicycle logical left shifter. One 2:1 mux row is reused every cycle;
// the latched operand walks through the 16, 8, 4, 2, 1 stages in that order,
// one stage per clock, so latency is SHAMT_BITS cycles for any shift amount.
module sll_sequential #(
    parameter int SHAMT_BITS = 5,
    parameter int WIDTH      = 32   // must equal 2**SHAMT_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ctrl_start,
    input  logic [WIDTH-1:0]      data_operandA,
    input  logic [SHAMT_BITS-1:0] ctrl_shiftamt,
    output logic [WIDTH-1:0]      data_result,
    output logic                  data_resultRDY,
    output logic                  busy
);

    localparam int CNT_W = (SHAMT_BITS > 1) ? $clog2(SHAMT_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(SHAMT_BITS - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]            state;
    logic [CNT_W-1:0]      stage_cnt;
    logic [SHAMT_BITS-1:0] shamt_q;
    logic [WIDTH-1:0]      work;

    logic [CNT_W-1:0]      stage_idx;
    logic [SHAMT_BITS-1:0] stage_amt;
    logic [WIDTH-1:0]      stage_out;

    // One mux row: shift by 2**idx when the shamt bit for this stage is set.
    // The stage counter runs upward, so the bit index counts down from the MSB.
    always_comb begin
        stage_idx = LAST_STAGE - stage_cnt;
        stage_amt = shamt_q & (SHAMT_BITS'(1) << stage_idx);
        stage_out = work << stage_amt;
    end

    assign busy = (state == SHIFT);

    // Sequencer: latch operands on start, apply one stage per cycle, publish
    // the last stage straight into data_result with a one-cycle RDY pulse.
    // NOTE: every register here uses <= so all reads in a cycle see pre-edge
    // values; a blocking write would let later statements see the new value.
    // NOTE: the working and shamt registers are reset too, so nothing in the
    // datapath is ever X after reset even though they are not observable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            stage_cnt      <= '0;
            shamt_q        <= '0;
            work           <= '0;
            data_result    <= '0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl_start) begin
                        work      <= data_operandA;
                        shamt_q   <= ctrl_shiftamt;
                        stage_cnt <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (stage_cnt == LAST_STAGE) begin
                        data_result    <= stage_out;
                        data_resultRDY <= 1'b1;
                        stage_cnt      <= '0;
                        state          <= IDLE;
                    end else begin
                        work      <= stage_out;
                        stage_cnt <= stage_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
